// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode classes,
// opcode range boundaries and ALUOp codes.
// Pure definitions, no logic; imported by the decoder and the FSM top.
package ctrl_pkg;

    // FSM state encoding. This is a flat binary code so that it stays
    // compatible with older tooling that consumes the raw state value.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEMACC = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    // Instruction class, latched during DECODE and used for the rest of the instruction.
    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_IMM     = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    // Opcode ranges (inclusive) for each class. Anything outside them is illegal.
    localparam int unsigned OP_R         = 0;
    localparam int unsigned OP_JUMP_LO   = 1;
    localparam int unsigned OP_JUMP_HI   = 2;
    localparam int unsigned OP_BRANCH_LO = 4;
    localparam int unsigned OP_BRANCH_HI = 7;
    localparam int unsigned OP_IMM_LO    = 8;
    localparam int unsigned OP_IMM_HI    = 14;
    localparam int unsigned OP_LOAD_LO   = 32;
    localparam int unsigned OP_LOAD_HI   = 37;
    localparam int unsigned OP_STORE_LO  = 40;
    localparam int unsigned OP_STORE_HI  = 46;

    // ALUOp codes as seen by the ALU control block.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    // Inclusive range test used by the opcode classifier.
    function automatic logic in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Maps the raw IR opcode onto one of the instruction classes.
// Purely combinational, zero latency; no handshake of its own.
// The FSM samples the class only in DECODE, so glitches elsewhere are harmless.
module opcode_class_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [2:0]          op_class_o
);

    int unsigned op_val;

    // Widen once so every range test compares plain unsigned integers.
    assign op_val = 32'(opcode_i);

    // Ranges are disjoint, so the order of the tests does not matter.
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (op_val == OP_R) begin
            op_class_o = CLS_R;
        end else if (in_range(op_val, OP_JUMP_LO, OP_JUMP_HI)) begin
            op_class_o = CLS_JUMP;
        end else if (in_range(op_val, OP_BRANCH_LO, OP_BRANCH_HI)) begin
            op_class_o = CLS_BRANCH;
        end else if (in_range(op_val, OP_IMM_LO, OP_IMM_HI)) begin
            op_class_o = CLS_IMM;
        end else if (in_range(op_val, OP_LOAD_LO, OP_LOAD_HI)) begin
            op_class_o = CLS_LOAD;
        end else if (in_range(op_val, OP_STORE_LO, OP_STORE_HI)) begin
            op_class_o = CLS_STORE;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEMACC/WB with memory timeout trap.
// Controls follow the registered state; only the ready-completion strobes are qualified by mem_ready.
// Memory requests are held until mem_ready; TIMEOUT+1 unready cycles in a wait state trap for good.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                RegDst,
    output logic                Branch,
    output logic                Jump,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOP,
    output logic                RegWrite,
    output logic                instr_done,
    output logic                trap
);

    // Counter is wide enough to hold TIMEOUT itself; it stops there and never wraps.
    localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [2:0]       class_q, class_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       dec_class;
    logic             wait_expired;

    opcode_class_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode_i   (opcode),
        .op_class_o (dec_class)
    );

    // A wait state has already burned TIMEOUT unready cycles.
    assign wait_expired = (cnt_q == CNT_MAX);

    // State, latched class and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            class_q <= CLS_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is cleared on every entry into FETCH or MEMACC.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_FETCH: begin
                // Ready on the expiry cycle still completes the fetch.
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_class == CLS_ILLEGAL) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R, CLS_IMM: begin
                        state_d = ST_WB;
                    end
                    CLS_BRANCH, CLS_JUMP: begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = ST_MEMACC;
                        cnt_d   = '0;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end
            ST_MEMACC: begin
                if (mem_ready) begin
                    if (class_q == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Datapath controls decoded from the registered state and latched class.
    // IDLE (and therefore reset) and DECODE leave every control low.
    always_comb begin
        RegDst     = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        ALUOP      = ALUOP_W'(ALU_ADD);
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Read at PC; PC+4 and IR are committed only when the word arrives.
                MemRead = 1'b1;
                IorD    = 1'b0;
                ALUOP   = ALUOP_W'(ALU_ADD);
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE: begin
                // ALU computes the branch target speculatively.
                ALUOP = ALUOP_W'(ALU_ADD);
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R: begin
                        ALUOP = ALUOP_W'(ALU_FUNCT);
                    end
                    CLS_IMM: begin
                        ALUSrc = 1'b1;
                        ALUOP  = ALUOP_W'(ALU_IMM);
                    end
                    CLS_BRANCH: begin
                        Branch     = 1'b1;
                        ALUOP      = ALUOP_W'(ALU_SUB);
                        instr_done = 1'b1;
                    end
                    CLS_JUMP: begin
                        Jump       = 1'b1;
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ALUSrc = 1'b1;
                        ALUOP  = ALUOP_W'(ALU_ADD);
                    end
                    default: begin
                        ALUOP = ALUOP_W'(ALU_ADD);
                    end
                endcase
            end
            ST_MEMACC: begin
                // Exactly one of MemRead/MemWrite, held for the whole wait.
                IorD = 1'b1;
                if (class_q == CLS_LOAD) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
            end
            ST_WB: begin
                RegWrite   = 1'b1;
                RegDst     = (class_q == CLS_R);
                MemtoReg   = (class_q == CLS_LOAD);
                instr_done = 1'b1;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised bench for multicycle_control_unit against an instruction-level reference model.
module tb_multicycle_control_unit;

    localparam int TO = 15;

    // Model phases and classes (bench-local numbering).
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXEC  = 3;
    localparam int P_MEM   = 4;
    localparam int P_WB    = 5;
    localparam int P_TRAP  = 6;

    localparam int K_R = 0, K_J = 1, K_B = 2, K_I = 3, K_L = 4, K_S = 5, K_X = 6;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       RegDst, Branch, Jump, PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic       MemtoReg, ALUSrc, RegWrite, instr_done, trap;
    logic [1:0] ALUOP;
    logic [15:0] obs_vec;

    int n_tests = 0;
    int n_fail  = 0;

    int ph     = P_IDLE;
    int cls    = K_R;
    int streak = 0;
    int plan[$];

    string pname[7] = '{"idle", "fetch", "decode", "exec", "memacc", "wb", "trap"};
    int legal_ops[14]  = '{0, 1, 2, 4, 7, 8, 11, 14, 32, 35, 37, 40, 43, 46};
    int illegal_ops[9] = '{3, 15, 16, 20, 31, 38, 39, 47, 63};

    multicycle_control_unit #(
        .OPCODE_W (6),
        .ALUOP_W  (2),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .RegDst     (RegDst),
        .Branch     (Branch),
        .Jump       (Jump),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .ALUOP      (ALUOP),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .trap       (trap)
    );

    assign obs_vec = {1'b0, RegDst, Branch, Jump, PCWrite, IRWrite, IorD, MemRead, MemWrite,
                      MemtoReg, ALUSrc, ALUOP, RegWrite, instr_done, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b want %b", tag, $time, obs, exp);
        end
    endtask

    function automatic int classify(input int op);
        if (op == 0)                   return K_R;
        if (op >= 1  && op <= 2)       return K_J;
        if (op >= 4  && op <= 7)       return K_B;
        if (op >= 8  && op <= 14)      return K_I;
        if (op >= 32 && op <= 37)      return K_L;
        if (op >= 40 && op <= 46)      return K_S;
        return K_X;
    endfunction

    // Control word the datapath should see in a given phase of an instruction.
    function automatic logic [15:0] expect_vec(input int p, input int c, input logic rdy);
        logic rd, br, jp, pcw, irw, iord, mrd, mwr, m2r, asrc, rw, dn, tr;
        logic [1:0] aop;
        {rd, br, jp, pcw, irw, iord, mrd, mwr, m2r, asrc, rw, dn, tr} = '0;
        aop = 2'b00;
        if (p == P_FETCH) begin
            mrd = 1'b1; irw = rdy; pcw = rdy;
        end else if (p == P_EXEC) begin
            if (c == K_R) aop = 2'b10;
            if (c == K_I) begin asrc = 1'b1; aop = 2'b11; end
            if (c == K_B) begin br = 1'b1; aop = 2'b01; dn = 1'b1; end
            if (c == K_J) begin jp = 1'b1; pcw = 1'b1; dn = 1'b1; end
            if (c == K_L || c == K_S) asrc = 1'b1;
        end else if (p == P_MEM) begin
            iord = 1'b1;
            if (c == K_L) mrd = 1'b1;
            if (c == K_S) begin mwr = 1'b1; dn = rdy; end
        end else if (p == P_WB) begin
            rw = 1'b1; dn = 1'b1;
            rd  = (c == K_R);
            m2r = (c == K_L);
        end else if (p == P_TRAP) begin
            tr = 1'b1;
        end
        return {1'b0, rd, br, jp, pcw, irw, iord, mrd, mwr, m2r, asrc, aop, rw, dn, tr};
    endfunction

    task automatic next_from_plan();
        streak = 0;
        if (plan.size() == 0) ph = P_FETCH;
        else ph = plan.pop_front();
    endtask

    // Instruction-level model: a wait phase fails once its unready streak exceeds TO.
    task automatic advance(input logic rdy);
        case (ph)
            P_IDLE: begin ph = P_FETCH; streak = 0; end
            P_FETCH, P_MEM: begin
                if (rdy) begin
                    if (ph == P_FETCH) begin ph = P_DEC; streak = 0; end
                    else next_from_plan();
                end else begin
                    streak++;
                    if (streak > TO) ph = P_TRAP;
                end
            end
            P_DEC: begin
                cls = classify(int'(opcode));
                plan.delete();
                case (cls)
                    K_R, K_I: plan = '{P_EXEC, P_WB};
                    K_B, K_J: plan = '{P_EXEC};
                    K_L:      plan = '{P_EXEC, P_MEM, P_WB};
                    K_S:      plan = '{P_EXEC, P_MEM};
                    default:  plan.delete();
                endcase
                if (cls == K_X) ph = P_TRAP;
                else next_from_plan();
            end
            P_EXEC, P_WB: next_from_plan();
            default: ph = P_TRAP;
        endcase
    endtask

    task automatic model_reset();
        ph = P_IDLE; streak = 0; plan.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_async", obs_vec, 16'h0000);
        model_reset();
        @(negedge clk);
        chk("reset_hold", obs_vec, 16'h0000);
        rst_n = 1'b1;
    endtask

    // pct < 0: ready only once the streak has reached TO (exact boundary case).
    task automatic run_episode(input int n_cycles, input int pct, input int force_op,
                               input bit mid_reset);
        bit did_mid = 1'b0;
        int trap_cycles = 0;
        apply_reset();
        for (int i = 0; i < n_cycles; i++) begin
            if (ph == P_FETCH || ph == P_IDLE) begin
                if (force_op >= 0)
                    opcode = 6'(force_op);
                else if ($urandom_range(9) == 0)
                    opcode = 6'(illegal_ops[$urandom_range(8)]);
                else
                    opcode = 6'(legal_ops[$urandom_range(13)]);
            end
            if (pct < 0) mem_ready = (streak >= TO);
            else         mem_ready = ($urandom_range(99) < pct);
            #1;
            chk(pname[ph], obs_vec, expect_vec(ph, cls, mem_ready));
            @(posedge clk);
            advance(mem_ready);
            if (mid_reset && !did_mid && ph == P_MEM) begin
                did_mid = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                chk("reset_mid_memacc", obs_vec, 16'h0000);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
            if (ph == P_TRAP) begin
                trap_cycles++;
                if (trap_cycles > 20) break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = '0;
        mem_ready = 1'b0;
        // Zero-wait memory, then a fetch that never completes.
        run_episode(150, 100, -1, 1'b0);
        run_episode(40, 0, -1, 1'b0);
        // Ready arriving exactly on the expiry cycle of every wait.
        run_episode(200, -1, -1, 1'b0);
        // Loads and stores with a slow memory, abandoned mid-access.
        run_episode(200, 40, 35, 1'b1);
        run_episode(200, 40, 43, 1'b1);
        run_episode(30, 100, 20, 1'b0);
        run_episode(300, 10, -1, 1'b0);
        for (int e = 0; e < 12; e++) begin
            run_episode(300, int'($urandom_range(5, 100)), -1, bit'($urandom_range(1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
